// File: rtl/bw_frame_sequencer.sv
// Purpose : walks an RGB frame buffer and writes (R+G+B)/3 luminance into a destination buffer.
// Latency : 3 cycles per pixel (READ, LATCH, WRITE) plus stall cycles; done pulses one cycle after the last accepted write.
// Backpres: wr_en/wr_addr/wr_data are held unchanged in WRITE until wr_ready; no new reads are issued meanwhile.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        frame request (IDLE only), synchronous cancel (READ/LATCH/WRITE)
//   busy, done          frame in progress, one-cycle completion pulse
//   rd_en, rd_addr      source RAM read strobe and pixel index
//   rd_data             source pixel {R,G,B}, valid one cycle after rd_en
//   wr_en, wr_addr,
//   wr_data, wr_ready   destination write request, index, gray value, accept
module bw_frame_sequencer #(
  parameter int ADDR_W = 17,
  parameter int NPIX   = 76800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic [2:0]        w_next;
  logic [ADDR_W-1:0] w_idx_next;
  logic [9:0]        w_sum;
  logic [7:0]        w_gray;

  // 10-bit sum cannot overflow (max 765), so the quotient always fits in 8 bits.
  assign w_sum  = {2'b00, rd_data[23:16]} + {2'b00, rd_data[15:8]} + {2'b00, rd_data[7:0]};
  assign w_gray = 8'(w_sum / 10'd3);

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_READ;
          w_idx_next = '0;
        end
      end
      S_READ:  w_next = abort ? S_IDLE : S_LATCH;
      S_LATCH: w_next = abort ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (wr_ready) begin
          // Completion is detected on the last index, so the index never wraps.
          if (r_idx == LAST_IDX) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_READ;
            w_idx_next = r_idx + ADDR_W'(1);
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Every output is a register decoded from the next state, so nothing
  // combinational reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      r_busy  <= (w_next == S_READ) || (w_next == S_LATCH) || (w_next == S_WRITE);
      r_done  <= (w_next == S_DONE);
      r_rd_en <= (w_next == S_READ);
      r_wr_en <= (w_next == S_WRITE);
      if (w_next == S_READ) begin
        r_rd_addr <= w_idx_next;
      end
      // Capture only on a real LATCH->WRITE step; an aborted LATCH leaves the
      // write port untouched.
      if ((r_state == S_LATCH) && (w_next == S_WRITE)) begin
        r_wr_addr <= r_idx;
        r_wr_data <= w_gray;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_bw_frame_sequencer.sv
module tb_bw_frame_sequencer;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  // ---------------- DUT with NPIX=4 ----------------
  logic start4 = 0, abort4 = 0, wr_ready4 = 1;
  logic busy4, done4, rd_en4, wr_en4;
  logic [AW-1:0] rd_addr4, wr_addr4;
  logic [23:0] rd_data4 = '0;
  logic [7:0] wr_data4;
  logic [23:0] mem4 [4];

  bw_frame_sequencer #(.ADDR_W(AW), .NPIX(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rd_data(rd_data4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .wr_ready(wr_ready4)
  );
  always @(posedge clk) if (rd_en4) rd_data4 <= mem4[rd_addr4[1:0]];

  // ---------------- DUT with NPIX=1 ----------------
  logic start1 = 0, abort1 = 0, wr_ready1 = 1;
  logic busy1, done1, rd_en1, wr_en1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [23:0] rd_data1 = '0;
  logic [7:0] wr_data1;
  logic [23:0] mem1 = '0;

  bw_frame_sequencer #(.ADDR_W(AW), .NPIX(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .wr_ready(wr_ready1)
  );
  always @(posedge clk) if (rd_en1) rd_data1 <= mem1;

  // ---------------- DUT with NPIX=8 (reset mid-frame) ----------------
  logic start8 = 0, abort8 = 0, wr_ready8 = 1;
  logic busy8, done8, rd_en8, wr_en8;
  logic [AW-1:0] rd_addr8, wr_addr8;
  logic [23:0] rd_data8 = '0;
  logic [7:0] wr_data8;
  logic [23:0] mem8 [8];

  bw_frame_sequencer #(.ADDR_W(AW), .NPIX(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .busy(busy8), .done(done8), .rd_en(rd_en8), .rd_addr(rd_addr8),
    .rd_data(rd_data8), .wr_en(wr_en8), .wr_addr(wr_addr8),
    .wr_data(wr_data8), .wr_ready(wr_ready8)
  );
  always @(posedge clk) if (rd_en8) rd_data8 <= mem8[rd_addr8[2:0]];

  // ---------------- monitors (sampled on the falling edge) ----------------
  int t04 = 0, t01 = 0;
  logic [11:0] wlog4[$];
  logic [11:0] wlog1[$];
  int done_cyc4[$];
  int done_cyc1[$];
  int busy_first4 = 0, busy_last4 = 0, busy_n4 = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if (wr_en4 && wr_ready4) wlog4.push_back({wr_addr4, wr_data4});
    if (done4) done_cyc4.push_back(cyc - t04);
    if (busy4) begin
      if (busy_n4 == 0) busy_first4 = cyc - t04;
      busy_last4 = cyc - t04;
      busy_n4++;
    end
    if (wr_en1 && wr_ready1) wlog1.push_back({wr_addr1, wr_data1});
    if (done1) done_cyc1.push_back(cyc - t01);
    if ((rd_en4 && wr_en4) || (rd_en1 && wr_en1) || (rd_en8 && wr_en8)) overlap++;
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic [23:0]   rgb;
    logic [AW-1:0] addr;
    logic [7:0]    gray;
  } vec_t;

  vec_t tab4[4];
  vec_t tab1[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge (cycle 0); returns in cycle 1.
  task automatic launch(input int w);
    case (w)
      4: start4 = 1'b1;
      1: start1 = 1'b1;
      default: start8 = 1'b1;
    endcase
    tick;
    start4 = 1'b0;
    start1 = 1'b0;
    start8 = 1'b0;
    if (w == 4) t04 = cyc - 1;
    if (w == 1) t01 = cyc - 1;
  endtask

  // Returns inside the DONE cycle, or with ok=0 once the budget runs out.
  task automatic wait_done(input int w, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick;
      ok = (w == 4) ? done4 : done1;
    end
  endtask

  task automatic clear4;
    wlog4.delete();
    done_cyc4.delete();
    busy_n4 = 0;
    busy_first4 = 0;
    busy_last4 = 0;
  endtask

  task automatic check_frame4(input string nm);
    chk({nm, " nwr"}, wlog4.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog4.size()) chk({nm, " wr"}, wlog4[i], {tab4[i].addr, tab4[i].gray});
  endtask

  bit ok;
  logic [7:0] held;

  initial begin
    tab4[0] = '{24'hFFFFFF, 4'd0, 8'hFF};
    tab4[1] = '{24'h010100, 4'd1, 8'h00};
    tab4[2] = '{24'h0A141E, 4'd2, 8'h14};
    tab4[3] = '{24'h640000, 4'd3, 8'h21};

    tab1[0] = '{24'h030303, 4'd0, 8'h03};
    tab1[1] = '{24'h000000, 4'd0, 8'h00};
    tab1[2] = '{24'hFFFFFF, 4'd0, 8'hFF};
    tab1[3] = '{24'hFF0000, 4'd0, 8'h55};
    tab1[4] = '{24'h000102, 4'd0, 8'h01};
    tab1[5] = '{24'h000002, 4'd0, 8'h00};
    tab1[6] = '{24'h7F8081, 4'd0, 8'h80};
    tab1[7] = '{24'hFEFFFF, 4'd0, 8'hFE};
    tab1[8] = '{24'h5A5A5B, 4'd0, 8'h5A};
    tab1[9] = '{24'h0000FF, 4'd0, 8'h55};

    for (int i = 0; i < 4; i++) mem4[i] = tab4[i].rgb;
    for (int i = 0; i < 8; i++) mem8[i] = 24'h102030 + 24'(i);

    // ---- reset values ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", busy4, 0);
    chk("rst done", done4, 0);
    chk("rst rd_en", rd_en4, 0);
    chk("rst rd_addr", rd_addr4, 0);
    chk("rst wr_en", wr_en4, 0);
    chk("rst wr_addr", wr_addr4, 0);
    chk("rst wr_data", wr_data4, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;

    // ---- NPIX=4 full frame, no back-pressure ----
    clear4;
    launch(4);
    chk("A rd_addr c1", rd_addr4, 0);
    chk("A rd_en c1", rd_en4, 1);
    wait_done(4, 100, ok);
    chk("A done seen", ok, 1);
    tick; tick;
    check_frame4("A");
    chk("A ndone", done_cyc4.size(), 1);
    if (done_cyc4.size() > 0) chk("A done cycle", done_cyc4[0], 13);
    chk("A busy first", busy_first4, 1);
    chk("A busy last", busy_last4, 12);
    chk("A busy cycles", busy_n4, 12);

    // ---- back-pressure: 5 stall cycles on pixel 2 ----
    clear4;
    launch(4);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (wr_en4 && wr_addr4 == 4'd2) ok = 1'b1;
      else tick;
    end
    chk("B pixel2 write seen", ok, 1);
    held = wr_data4;
    wr_ready4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) wr_ready4 = 1'b0;
      tick;
      chk("B stall wr_en", wr_en4, 1);
      chk("B stall wr_addr", wr_addr4, 2);
      chk("B stall wr_data", wr_data4, held);
      chk("B stall rd_en", rd_en4, 0);
    end
    wr_ready4 = 1'b1;
    wait_done(4, 100, ok);
    chk("B done seen", ok, 1);
    tick; tick;
    check_frame4("B");
    if (done_cyc4.size() > 0) chk("B done cycle", done_cyc4[0], 18);

    // ---- abort in LATCH of pixel 1 ----
    clear4;
    launch(4);
    tick; tick; tick;                      // cycle 4: READ of pixel 1
    chk("C read p1 addr", rd_addr4, 1);
    tick;                                  // cycle 5: LATCH of pixel 1
    chk("C latch rd_en", rd_en4, 0);
    abort4 = 1'b1;
    tick;
    abort4 = 1'b0;
    chk("C busy after abort", busy4, 0);
    chk("C wr_en after abort", wr_en4, 0);
    chk("C rd_en after abort", rd_en4, 0);
    repeat (12) tick;
    chk("C no done", done_cyc4.size(), 0);
    chk("C nwr", wlog4.size(), 1);
    if (wlog4.size() > 0) chk("C only addr0 written", wlog4[0][11:8], 0);
    launch(4);
    chk("C restart rd_en", rd_en4, 1);
    chk("C restart rd_addr", rd_addr4, 0);
    wait_done(4, 100, ok);
    chk("C restart done seen", ok, 1);
    tick; tick;

    // ---- start ignored in READ and DONE, accepted in following IDLE ----
    clear4;
    launch(4);
    start4 = 1'b1;                         // sampled while in READ
    tick;
    start4 = 1'b0;
    wait_done(4, 100, ok);
    chk("D done seen", ok, 1);
    start4 = 1'b1;                         // sampled while in DONE
    tick;
    start4 = 1'b0;
    chk("D idle busy", busy4, 0);
    chk("D idle rd_en", rd_en4, 0);
    chk("D ndone pass1", done_cyc4.size(), 1);
    if (done_cyc4.size() > 0) chk("D done cycle pass1", done_cyc4[0], 13);
    check_frame4("D1");
    launch(4);
    chk("D pass2 rd_en", rd_en4, 1);
    chk("D pass2 rd_addr", rd_addr4, 0);
    wait_done(4, 100, ok);
    chk("D pass2 done seen", ok, 1);
    tick; tick;
    chk("D ndone total", done_cyc4.size(), 2);
    if (done_cyc4.size() > 1) chk("D done cycle pass2", done_cyc4[1], 13);

    // ---- NPIX=1 luminance vectors, one single-pixel frame each ----
    for (int i = 0; i < 10; i++) begin
      mem1 = tab1[i].rgb;
      wlog1.delete();
      done_cyc1.delete();
      launch(1);
      wait_done(1, 20, ok);
      chk("E done seen", ok, 1);
      tick; tick;
      chk("E nwr", wlog1.size(), 1);
      if (wlog1.size() > 0) chk("E wr", wlog1[0], {tab1[i].addr, tab1[i].gray});
      chk("E done cycle", (done_cyc1.size() > 0) ? done_cyc1[0] : -1, 4);
    end

    // ---- asynchronous reset during WRITE of pixel 5 ----
    launch(8);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (wr_en8 && wr_addr8 == 4'd5) ok = 1'b1;
      else tick;
    end
    chk("F pixel5 write seen", ok, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("F rst busy", busy8, 0);
    chk("F rst done", done8, 0);
    chk("F rst rd_en", rd_en8, 0);
    chk("F rst rd_addr", rd_addr8, 0);
    chk("F rst wr_en", wr_en8, 0);
    chk("F rst wr_addr", wr_addr8, 0);
    chk("F rst wr_data", wr_data8, 0);
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
    chk("F idle busy", busy8, 0);
    chk("F idle rd_en", rd_en8, 0);
    chk("F idle wr_en", wr_en8, 0);
    launch(8);
    chk("F restart rd_en", rd_en8, 1);
    chk("F restart rd_addr", rd_addr8, 0);

    chk("rd_en/wr_en overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
